// File: rtl/mcontr_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mcontr_arbiter_rr
//
// SDRAM access arbiter for the memory controller. Arbitrates NCHN requesters
// (index NCHN-1 is the refresh channel by convention) at two priority levels:
//   - urgent requests: fixed priority, lowest index wins;
//   - normal requests: round-robin, the search starts one past the last
//     normal-level grant, so no low-index channel can starve the others.
// The selected channel is presented on 'channel' one cycle before the one-hot
// 'start' pulse; line read/write strobes accompany the start pulse, and the
// SDDO mux select follows the start pulse after SDDO_DLY cycles.
//
// Everything runs on the falling edge of clk0, like the rest of mcontr.
//
// Ports:
//   clk0        in   1     system clock (negedge active)
//   rst         in   1     synchronous active-high reset
//   chn_wnr     in   NCHN  per-channel direction (1 = write), used for DYN_MASK
//   init_chn    in   NCHN  masks requests and clears busy of those channels
//   rq          in   NCHN  normal-priority requests
//   rq_urgent   in   NCHN  urgent requests
//   next        in   1     sequencer pulse: current access is retiring
//   start       out  NCHN  one-hot, one-cycle start pulse
//   start_lnwr  out  1     line-write start, coincident with start
//   start_lnrd  out  1     line-read start, coincident with start
//   channel     out  NCHN  one-hot select, held until the next grant
//   sddo_sel    out  NCHN  delayed channel & SDDO_MASK
//   rq_busy     out  NCHN  rq | busy (combinational)
// -----------------------------------------------------------------------------
module mcontr_arbiter_rr #(
  parameter int              NCHN      = 9,
  parameter int              LEAD      = 2,
  parameter logic [NCHN-1:0] WR_MASK   = 9'h015,
  parameter logic [NCHN-1:0] RD_MASK   = 9'h022,
  parameter logic [NCHN-1:0] DYN_MASK  = 9'h008,
  parameter logic [NCHN-1:0] SDDO_MASK = 9'h03f,
  parameter int              SDDO_DLY  = 3
) (
  input  logic            clk0,
  input  logic            rst,
  input  logic [NCHN-1:0] chn_wnr,
  input  logic [NCHN-1:0] init_chn,
  input  logic [NCHN-1:0] rq,
  input  logic [NCHN-1:0] rq_urgent,
  input  logic            next,
  output logic [NCHN-1:0] start,
  output logic            start_lnwr,
  output logic            start_lnrd,
  output logic [NCHN-1:0] channel,
  output logic [NCHN-1:0] sddo_sel,
  output logic [NCHN-1:0] rq_busy
);

  localparam int IW = (NCHN > 1) ? $clog2(NCHN) : 1;
  localparam int CW = 4;  // LEAD is at most 15

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2,
    BUSY   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Request capture
  logic [NCHN-1:0] frz_u_reg, frz_u_next;
  logic [NCHN-1:0] frz_n_reg, frz_n_next;
  logic            pend_reg, pend_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // Grant bookkeeping
  logic [NCHN-1:0] busy_reg, busy_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]   win_idx_reg, win_idx_next;
  logic            win_norm_reg, win_norm_next;

  // Output registers
  logic [NCHN-1:0] channel_reg, channel_next;
  logic [NCHN-1:0] start_reg, start_next;
  logic            start_lnwr_reg, start_lnwr_next;
  logic            start_lnrd_reg, start_lnrd_next;
  logic [NCHN-1:0] sddo_sel_reg, sddo_sel_next;
  logic [SDDO_DLY-1:0] dly_reg, dly_next;

  // Combinational helpers
  logic [NCHN-1:0] mu, mn;
  logic [NCHN-1:0] cand_u, cand_n;
  logic [NCHN-1:0] wr_en, rd_en;
  logic [IW-1:0]   urg_idx, rr_idx, win_idx;
  logic            rr_hit, win_any, win_is_norm;
  logic [NCHN-1:0] win_vec;

  assign mu = rq_urgent & ~init_chn;
  assign mn = rq & ~init_chn;

  // init_chn is applied again at selection time, so a channel initialised
  // while its request sits in the frozen copy is dropped rather than granted.
  assign cand_u = frz_u_reg & ~init_chn;
  assign cand_n = frz_n_reg & ~init_chn;

  assign rq_busy = rq | busy_reg;

  genvar gi;
  generate
    // Per-channel line direction: fixed write/read channels plus the
    // dynamic ones that take their direction from chn_wnr.
    for (gi = 0; gi < NCHN; gi++) begin : g_dir
      assign wr_en[gi] = WR_MASK[gi] | (DYN_MASK[gi] & chn_wnr[gi]);
      assign rd_en[gi] = RD_MASK[gi] | (DYN_MASK[gi] & ~chn_wnr[gi]);
    end

    // sddo delay line: stage 0 is loaded on the edge that raises start,
    // so the last stage is set SDDO_DLY-1 edges later and sddo_sel moves
    // exactly SDDO_DLY edges after the start edge.
    for (gi = 0; gi < SDDO_DLY; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        assign dly_next[gi] = (state_reg == GRANT);
      end else begin : g_tail
        assign dly_next[gi] = dly_reg[gi-1];
      end
    end
  endgenerate

  // Urgent level: lowest set index. Scanning downwards lets the lowest
  // index overwrite any higher one found earlier.
  always_comb begin
    urg_idx = '0;
    for (int i = NCHN - 1; i >= 0; i--) begin
      if (cand_u[IW'(i)]) begin
        urg_idx = IW'(i);
      end
    end
  end

  // Normal level: first set bit at rr_ptr+1, rr_ptr+2, ... wrapping at NCHN.
  // Offsets are scanned from farthest to nearest so the nearest hit sticks.
  always_comb begin
    int pos_int;
    pos_int = 0;
    rr_idx  = '0;
    rr_hit  = 1'b0;
    for (int k = NCHN; k >= 1; k--) begin
      pos_int = int'(rr_ptr_reg) + k;
      if (pos_int >= NCHN) begin
        pos_int = pos_int - NCHN;
      end
      if (cand_n[IW'(pos_int)]) begin
        rr_idx = IW'(pos_int);
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    win_any     = 1'b0;
    win_is_norm = 1'b0;
    win_idx     = '0;
    win_vec     = '0;
    if (|cand_u) begin
      win_any = 1'b1;
      win_idx = urg_idx;
    end else if (rr_hit) begin
      win_any     = 1'b1;
      win_is_norm = 1'b1;
      win_idx     = rr_idx;
    end
    if (win_any) begin
      win_vec[win_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk0) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pend_reg) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = win_any ? GRANT : IDLE;
        end
      end
      GRANT: begin
        state_next = BUSY;
      end
      BUSY: begin
        // Leave on the same edge that clears busy (next or init_chn).
        if (busy_next == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    frz_u_next      = frz_u_reg;
    frz_n_next      = frz_n_reg;
    pend_next       = pend_reg;
    cnt_next        = cnt_reg;
    busy_next       = busy_reg;
    rr_ptr_next     = rr_ptr_reg;
    win_idx_next    = win_idx_reg;
    win_norm_next   = win_norm_reg;
    channel_next    = channel_reg;
    start_next      = '0;
    start_lnwr_next = 1'b0;
    start_lnrd_next = 1'b0;
    sddo_sel_next   = sddo_sel_reg;

    case (state_reg)
      IDLE: begin
        if (pend_reg) begin
          // The capture that raised pend stays frozen for the selection.
          pend_next = 1'b0;
          cnt_next  = CW'(LEAD - 1);
        end else begin
          frz_u_next = mu;
          frz_n_next = mn;
          pend_next  = |(mu | mn);
        end
      end
      SETTLE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (win_any) begin
          channel_next  = win_vec;
          win_idx_next  = win_idx;
          win_norm_next = win_is_norm;
        end
      end
      GRANT: begin
        // The busy load takes precedence over a coincident next pulse.
        start_next      = channel_reg;
        busy_next       = channel_reg & ~init_chn;
        start_lnwr_next = |(channel_reg & wr_en);
        start_lnrd_next = |(channel_reg & rd_en);
        if (win_norm_reg) begin
          rr_ptr_next = win_idx_reg;
        end
      end
      BUSY: begin
        busy_next = next ? '0 : (busy_reg & ~init_chn);
      end
      default: begin
      end
    endcase

    if (dly_reg[SDDO_DLY-1]) begin
      sddo_sel_next = channel_reg & SDDO_MASK;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk0) begin
    if (rst) begin
      frz_u_reg      <= '0;
      frz_n_reg      <= '0;
      pend_reg       <= 1'b0;
      cnt_reg        <= '0;
      busy_reg       <= '0;
      rr_ptr_reg     <= IW'(NCHN - 1);  // first normal search begins at 0
      win_idx_reg    <= '0;
      win_norm_reg   <= 1'b0;
      channel_reg    <= '0;
      start_reg      <= '0;
      start_lnwr_reg <= 1'b0;
      start_lnrd_reg <= 1'b0;
      sddo_sel_reg   <= '0;
      dly_reg        <= '0;
    end else begin
      frz_u_reg      <= frz_u_next;
      frz_n_reg      <= frz_n_next;
      pend_reg       <= pend_next;
      cnt_reg        <= cnt_next;
      busy_reg       <= busy_next;
      rr_ptr_reg     <= rr_ptr_next;
      win_idx_reg    <= win_idx_next;
      win_norm_reg   <= win_norm_next;
      channel_reg    <= channel_next;
      start_reg      <= start_next;
      start_lnwr_reg <= start_lnwr_next;
      start_lnrd_reg <= start_lnrd_next;
      sddo_sel_reg   <= sddo_sel_next;
      dly_reg        <= dly_next;
    end
  end

  assign start      = start_reg;
  assign start_lnwr = start_lnwr_reg;
  assign start_lnrd = start_lnrd_reg;
  assign channel    = channel_reg;
  assign sddo_sel   = sddo_sel_reg;

endmodule

// File: tb/tb_mcontr_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_mcontr_arbiter_rr
//
// Bench for mcontr_arbiter_rr. The DUT works on the falling clock edge; the
// bench samples outputs and then drives inputs on the rising edge.
// -----------------------------------------------------------------------------
module tb_mcontr_arbiter_rr;

  localparam int NCHN     = 9;
  localparam int LEAD     = 2;
  localparam int SDDO_DLY = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] chn_wnr, init_chn, rq, rq_urgent;
  logic       next;
  logic [8:0] start, channel, sddo_sel, rq_busy;
  logic       start_lnwr, start_lnrd;

  logic [3:0] chn_wnr4, init4, rq4, urg4;
  logic       next4;
  logic [3:0] start4, channel4, sddo4, rq_busy4;
  logic       lnwr4, lnrd4;

  mcontr_arbiter_rr #(
    .NCHN(9), .LEAD(LEAD), .WR_MASK(9'h015), .RD_MASK(9'h022),
    .DYN_MASK(9'h008), .SDDO_MASK(9'h03f), .SDDO_DLY(SDDO_DLY)
  ) dut (
    .clk0(clk), .rst(rst), .chn_wnr(chn_wnr), .init_chn(init_chn),
    .rq(rq), .rq_urgent(rq_urgent), .next(next), .start(start),
    .start_lnwr(start_lnwr), .start_lnrd(start_lnrd), .channel(channel),
    .sddo_sel(sddo_sel), .rq_busy(rq_busy)
  );

  mcontr_arbiter_rr #(
    .NCHN(4), .LEAD(1), .WR_MASK(4'h5), .RD_MASK(4'h2),
    .DYN_MASK(4'h8), .SDDO_MASK(4'hf), .SDDO_DLY(2)
  ) dut4 (
    .clk0(clk), .rst(rst), .chn_wnr(chn_wnr4), .init_chn(init4),
    .rq(rq4), .rq_urgent(urg4), .next(next4), .start(start4),
    .start_lnwr(lnwr4), .start_lnrd(lnrd4), .channel(channel4),
    .sddo_sel(sddo4), .rq_busy(rq_busy4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side expectations carried between transactions
  logic [8:0] prev_ch;
  logic [8:0] prev_sddo;
  int         model_rr;

  logic [8:0] wr_m   = 9'h015;
  logic [8:0] rd_m   = 9'h022;
  logic [8:0] dyn_m  = 9'h008;
  logic [8:0] sddo_m = 9'h03f;

  typedef struct {
    logic [8:0] r;
    logic [8:0] u;
    logic [8:0] w;
    logic [8:0] ch;
    logic       wr;
    logic       rd;
    logic [8:0] sd;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference choice: urgent -> lowest index; else first requester after the
  // last normal grant, going round the ring.
  function automatic int model_pick(input logic [8:0] r, input logic [8:0] u,
                                    output bit is_norm);
    is_norm = 1'b0;
    if (u != 9'h0) begin
      for (int i = 0; i < NCHN; i++) begin
        if (u[i]) return i;
      end
    end
    is_norm = 1'b1;
    for (int k = 1; k <= NCHN; k++) begin
      int idx;
      idx = (model_rr + k) % NCHN;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; rq = 9'h0a5; rq_urgent = '0; chn_wnr = '0; init_chn = '0; next = 1'b0;
    rq4 = '0; urg4 = '0; chn_wnr4 = '0; init4 = '0; next4 = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_channel", 32'(channel), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_lnwr", 32'(start_lnwr), 32'h0);
    chk("rst_lnrd", 32'(start_lnrd), 32'h0);
    chk("rst_sddo", 32'(sddo_sel), 32'h0);
    chk("rst_rq_busy", 32'(rq_busy), 32'h0a5);
    chk("rst_channel4", 32'(channel4), 32'h0);
    rst = 1'b0; rq = '0;
    repeat (3) @(posedge clk);
    prev_ch = '0; prev_sddo = '0; model_rr = NCHN - 1;
  endtask

  // One isolated grant starting from IDLE with nothing pending.
  task automatic do_txn(input int id, input logic [8:0] r, input logic [8:0] u,
                        input logic [8:0] w, input logic [8:0] ech, input logic ewr,
                        input logic erd, input logic [8:0] esd, input int nd);
    bit early;
    early = 1'b0;
    rq = r; rq_urgent = u; chn_wnr = w;
    for (int c = 1; c <= LEAD + 3; c++) begin
      @(posedge clk);
      if (c < LEAD + 3 && start != 9'h0) early = 1'b1;
      if (c == LEAD + 1) chk("txn_channel_old", 32'(channel), 32'(prev_ch));
      if (c == LEAD + 2) chk("txn_channel", 32'(channel), 32'(ech));
      if (c == LEAD + 3) begin
        chk("txn_start", 32'(start), 32'(ech));
        chk("txn_lnwr", 32'(start_lnwr), 32'(ewr));
        chk("txn_lnrd", 32'(start_lnrd), 32'(erd));
        chk("txn_rq_busy", 32'(rq_busy), 32'(r | ech));
        rq = '0; rq_urgent = '0;
      end
    end
    chk("txn_no_early_start", 32'(early), 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      if (c == 1) begin
        chk("txn_start_width", 32'(start), 32'h0);
        chk("txn_lnwr_width", 32'(start_lnwr), 32'h0);
        chk("txn_busy", 32'(rq_busy), 32'(ech));
      end
      if (c == SDDO_DLY - 1) chk("txn_sddo_old", 32'(sddo_sel), 32'(prev_sddo));
      if (c == SDDO_DLY) chk("txn_sddo", 32'(sddo_sel), 32'(esd));
      if (c == 8) chk("txn_busy_clear", 32'(rq_busy), 32'h0);
      next = (c == nd);
    end
    prev_ch = ech; prev_sddo = esd;
    $display("[TB] txn %0d rq=%h urg=%h wnr=%h -> start=%h lnwr=%0b lnrd=%0b",
             id, r, u, w, ech, ewr, erd);
  endtask

  initial begin
    logic [8:0] ch_h1, ch_h2, exp1, prev1;
    logic [8:0] seq1 [3];
    int ns, next_at, off_at, last_c, d_prev;
    bit done;

    tbl[0]  = '{9'h0ff, 9'h000, 9'h000, 9'h001, 1'b1, 1'b0, 9'h001};
    tbl[1]  = '{9'h0ff, 9'h000, 9'h000, 9'h002, 1'b0, 1'b1, 9'h002};
    tbl[2]  = '{9'h0ff, 9'h100, 9'h000, 9'h100, 1'b0, 1'b0, 9'h000};
    tbl[3]  = '{9'h0ff, 9'h000, 9'h000, 9'h004, 1'b1, 1'b0, 9'h004};
    tbl[4]  = '{9'h008, 9'h000, 9'h008, 9'h008, 1'b1, 1'b0, 9'h008};
    tbl[5]  = '{9'h008, 9'h000, 9'h000, 9'h008, 1'b0, 1'b1, 9'h008};
    tbl[6]  = '{9'h010, 9'h000, 9'h000, 9'h010, 1'b1, 1'b0, 9'h010};
    tbl[7]  = '{9'h040, 9'h000, 9'h000, 9'h040, 1'b0, 1'b0, 9'h000};
    tbl[8]  = '{9'h0a1, 9'h000, 9'h000, 9'h080, 1'b0, 1'b0, 9'h000};
    tbl[9]  = '{9'h0a1, 9'h000, 9'h000, 9'h001, 1'b1, 1'b0, 9'h001};
    tbl[10] = '{9'h0a1, 9'h0a0, 9'h000, 9'h020, 1'b0, 1'b1, 9'h020};
    tbl[11] = '{9'h0a1, 9'h000, 9'h000, 9'h020, 1'b0, 1'b1, 9'h020};
    tbl[12] = '{9'h000, 9'h022, 9'h000, 9'h002, 1'b0, 1'b1, 9'h002};
    tbl[13] = '{9'h0ff, 9'h000, 9'h000, 9'h040, 1'b0, 1'b0, 9'h000};

    // ---- Held rq = 0x006: ch1, ch2, ch1 ----
    do_reset();
    seq1[0] = 9'h002; seq1[1] = 9'h004; seq1[2] = 9'h002;
    rq = 9'h006;
    ch_h1 = '0; ch_h2 = '0; prev1 = '0;
    ns = 0; next_at = -1; off_at = -1; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      if (c == off_at) chk("t1_start_width", 32'(start), 32'h0);
      if (start != 9'h0 && c != off_at) begin
        if (ns < 3) begin
          exp1 = seq1[ns];
          chk("t1_grant", 32'(start), 32'(exp1));
          chk("t1_ch_one_before", 32'(ch_h1), 32'(exp1));
          chk("t1_ch_two_before", 32'(ch_h2), 32'(prev1));
          $display("[TB] t1 grant %0d start=%h at cycle %0d", ns, start, c);
          prev1 = exp1; next_at = c + 4; off_at = c + 1; ns++;
          if (ns == 3) rq = '0;
        end else begin
          chk("t1_extra_grant", 32'(start), 32'h0);
        end
      end
      next = (c == next_at);
      if (ns == 3 && c > next_at + 3) done = 1'b1;
      ch_h2 = ch_h1; ch_h1 = channel;
    end
    chk("t1_grant_count", 32'(ns), 32'd3);

    // ---- Table vectors (urgent refresh, direction, sddo mask, wrap) ----
    do_reset();
    for (int i = 0; i < 14; i++) begin
      do_txn(i, tbl[i].r, tbl[i].u, tbl[i].w, tbl[i].ch, tbl[i].wr, tbl[i].rd,
             tbl[i].sd, 1 + (i % 4));
    end

    // ---- init_chn during SETTLE drops the grant ----
    do_reset();
    rq = 9'h004;
    @(posedge clk);
    @(posedge clk);
    init_chn = 9'h004;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      if (start != 9'h0) done = 1'b1;
      if (c == 5) begin
        chk("t4_rq_busy_held", 32'(rq_busy), 32'h004);
        chk("t4_channel", 32'(channel), 32'h0);
        rq = '0;
      end
      if (c == 6) chk("t4_rq_busy_drop", 32'(rq_busy), 32'h0);
    end
    chk("t4_no_start", 32'(done), 32'h0);
    $display("[TB] t4 init_chn during settle: no grant issued");
    init_chn = '0;
    repeat (3) @(posedge clk);
    do_txn(100, 9'h004, 9'h000, 9'h000, 9'h004, 1'b1, 1'b0, 9'h004, 2);

    // ---- Reset on the cycle channel would update ----
    rq = 9'h010;
    done = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      if (start != 9'h0) done = 1'b1;
    end
    chk("t5_channel_before_rst", 32'(channel), 32'h004);
    rst = 1'b1;
    @(posedge clk);
    chk("t5_channel", 32'(channel), 32'h0);
    chk("t5_start", 32'(start), 32'h0);
    chk("t5_sddo", 32'(sddo_sel), 32'h0);
    chk("t5_lnwr", 32'(start_lnwr), 32'h0);
    chk("t5_rq_busy", 32'(rq_busy), 32'h010);
    rst = 1'b0; rq = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      if (start != 9'h0) done = 1'b1;
    end
    chk("t5_no_start", 32'(done), 32'h0);
    $display("[TB] t5 reset before grant: no start pulse");
    prev_ch = '0; prev_sddo = '0;
    do_txn(101, 9'h009, 9'h000, 9'h000, 9'h001, 1'b1, 1'b0, 9'h001, 3);

    // ---- Randomised transactions against the reference choice ----
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [8:0] r, u, w, ech, esd;
      logic ewr, erd;
      int p;
      bit isn;
      r = 9'($urandom);
      u = ($urandom_range(0, 3) == 0) ? (9'($urandom) & 9'($urandom)) : 9'h0;
      w = 9'($urandom);
      if ((r | u) == 9'h0) r = 9'h100;
      p = model_pick(r, u, isn);
      ech = '0;
      ech[p] = 1'b1;
      ewr = wr_m[p] | (dyn_m[p] & w[p]);
      erd = rd_m[p] | (dyn_m[p] & ~w[p]);
      esd = ech & sddo_m;
      do_txn(200 + t, r, u, w, ech, ewr, erd, esd, $urandom_range(1, 4));
      if (isn) model_rr = p;
    end

    // ---- NCHN = 4, LEAD = 1, rq held: 0,1,2,3,0,1 ----
    do_reset();
    rq4 = 4'hf;
    ns = 0; next_at = -1; off_at = -1; last_c = 0; d_prev = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      logic [3:0] e4;
      @(posedge clk);
      if (c == off_at) chk("t6_start_width", 32'(start4), 32'h0);
      if (start4 != 4'h0 && c != off_at) begin
        if (ns < 6) begin
          e4 = 4'b0001 << (ns % 4);
          chk("t6_grant", 32'(start4), 32'(e4));
          if (ns > 0) chk("t6_spacing", 32'(c - last_c), 32'(d_prev + 5));
          $display("[TB] t6 grant %0d start=%h at cycle %0d", ns, start4, c);
          d_prev = $urandom_range(1, 4);
          next_at = c + d_prev; off_at = c + 1; last_c = c; ns++;
          if (ns == 6) rq4 = '0;
        end else begin
          chk("t6_extra_grant", 32'(start4), 32'h0);
        end
      end
      next4 = (c == next_at);
      if (ns == 6 && c > next_at + 3) done = 1'b1;
    end
    chk("t6_grant_count", 32'(ns), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
